button_debounce: RTL and testbench

- Input-side counterpart to the LED output path: samples asynchronous board pushbuttons/DIP switches in the `clk` domain.
- Per bit: synchronises, debounces with a stable-time counter, and produces a clean level, one-cycle press/release pulses and a long-press "held" flag.
- Sits between the board input pins and user logic, which then drives the LEDs.

---
 rtl/button_debounce.sv | 89 ++++++++
 tb/tb_button_debounce.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Conditions board pushbuttons/DIP switches in the clk domain. Each bit is synchronised,
// debounced by a stable-time counter, and gets press/release pulses and a long-press flag.
module button_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 200000,
    parameter int HOLD_CYCLES   = 100000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_held
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    // Normalise polarity so that 1 always means pressed from the first sync flop on.
    logic [WIDTH-1:0] raw;
    assign raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic              sync_p0;
        logic              sync_p1;
        logic [CNT_W-1:0]  stable_cnt;
        logic [CNT_W-1:0]  stable_cnt_next;
        logic              level;
        logic              level_next;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_cnt_next;
        logic              press;
        logic              rel;
        logic              held;

        always_comb begin
            level_next      = level;
            stable_cnt_next = stable_cnt + CNT_W'(1);
            if (sync_p1 == level) begin
                stable_cnt_next = '0;
            end else if (stable_cnt == CNT_LAST) begin
                level_next      = sync_p1;
                stable_cnt_next = '0;
            end

            // Hold time starts counting the cycle after the level rises and is
            // cleared on the same edge the level falls, so held drops with release.
            hold_cnt_next = hold_cnt;
            if (!level || !level_next) begin
                hold_cnt_next = '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt_next = hold_cnt + HOLD_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_p0    <= 1'b0;
                sync_p1    <= 1'b0;
                stable_cnt <= '0;
                level      <= 1'b0;
                hold_cnt   <= '0;
                press      <= 1'b0;
                rel        <= 1'b0;
                held       <= 1'b0;
            end else begin
                sync_p0    <= raw[i];
                sync_p1    <= sync_p0;
                stable_cnt <= stable_cnt_next;
                level      <= level_next;
                hold_cnt   <= hold_cnt_next;
                press      <= level_next & ~level;
                rel        <= ~level_next & level;
                held       <= (hold_cnt_next == HOLD_MAX);
            end
        end

        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = rel;
        assign btn_held[i]    = held;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: active-high and active-low instances driven with the same
// logical stimulus, compared every cycle against a sliding-window/timestamp model.
module tb_button_debounce;

    localparam int WIDTH  = 8;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;
    localparam int HIST   = STABLE + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] btn_in;
    logic [WIDTH-1:0] btn_in_n;
    logic [WIDTH-1:0] btn_level, btn_press, btn_release, btn_held;
    logic [WIDTH-1:0] n_level, n_press, n_release, n_held;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign btn_in_n = ~btn_in;

    button_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_held(btn_held)
    );

    button_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in_n),
        .btn_level(n_level), .btn_press(n_press), .btn_release(n_release), .btn_held(n_held)
    );

    // Reference: a level is accepted once the last STABLE synchronised samples
    // (raw inputs from 2..STABLE+1 edges ago) all agree and differ from it.
    logic [WIDTH-1:0] hist [HIST];
    logic [WIDTH-1:0] m_level = '0, m_press = '0, m_release = '0, m_held = '0;
    logic [WIDTH-1:0] prev_level;
    int               rise_at [WIDTH];
    int               edge_n = 0;
    bit               all_same;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            for (int j = 0; j < HIST; j++) hist[j] = '0;
            m_level = '0; m_press = '0; m_release = '0; m_held = '0;
        end else begin
            for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0]    = btn_in;
            prev_level = m_level;
            for (int b = 0; b < WIDTH; b++) begin
                all_same = 1'b1;
                for (int j = 3; j <= STABLE + 1; j++)
                    if (hist[j][b] != hist[2][b]) all_same = 1'b0;
                if (all_same && hist[2][b] != m_level[b]) begin
                    m_level[b] = hist[2][b];
                    if (m_level[b]) rise_at[b] = edge_n;
                end
                m_held[b] = m_level[b] && ((edge_n - rise_at[b]) >= HOLD);
            end
            m_press   = m_level & ~prev_level;
            m_release = ~m_level & prev_level;
        end
    end

    logic [4*WIDTH-1:0] got_a, got_b, exp_v;
    assign got_a = {btn_level, btn_press, btn_release, btn_held};
    assign got_b = {n_level, n_press, n_release, n_held};
    assign exp_v = {m_level, m_press, m_release, m_held};

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = '1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (got_a !== '0 || got_b !== '0) begin
                errors++;
                $display("FAIL reset_clear got=%h inv=%h want=0", got_a, got_b);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== ((e >= 6) ? 8'hFF : 8'h00) || btn_press !== ((e == 6) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL reset_release_e%0d level=%h press=%h", e, btn_level, btn_press);
            end
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_reset got=%h inv=%h want=%h", got_a, got_b, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        btn_in = '0;
        repeat (10) @(negedge clk);
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== ((e >= 6) ? 8'h01 : 8'h00) || btn_press !== ((e == 6) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL clean_press_e%0d level=%h press=%h want_press=%0d", e, btn_level, btn_press, e == 6);
            end
        end
        repeat (15) @(negedge clk);
        btn_in[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (btn_release !== ((e == 6) ? 8'h01 : 8'h00) || btn_level[0] !== (e < 6)) begin
                errors++;
                $display("FAIL clean_release_e%0d level=%h release=%h", e, btn_level, btn_release);
            end
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_clean got=%h inv=%h want=%h", got_a, got_b, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        int n_press;
        int at;
        n_press = 0;
        at      = 0;
        btn_in  = '0;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 20; e++) begin
            btn_in[3] = !(e == 2 || e == 4);
            @(negedge clk);
            if (btn_press[3]) begin
                n_press++;
                at = e;
            end
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_bounce got=%h inv=%h want=%h", got_a, got_b, exp_v);
            end
        end
        checks++;
        if (n_press != 1 || at != 10) begin
            errors++;
            $display("FAIL bounce_press count=%0d edge=%0d want count=1 edge=10", n_press, at);
        end
        btn_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        n_press = 0;
        for (int e = 1; e <= 14; e++) begin
            btn_in[3] = (e <= 3);
            @(negedge clk);
            if (btn_press[3] || btn_level[3]) n_press++;
        end
        checks++;
        if (n_press != 0) begin
            errors++;
            $display("FAIL glitch_reject active_cycles=%0d want=0", n_press);
        end
    endtask

    task automatic test_long_press();
        int  r;
        bit  got;
        logic prev_held;
        btn_in = '0;
        repeat (10) @(negedge clk);
        btn_in[5] = 1'b1;
        r = 0;
        for (int e = 1; e <= 20 && r == 0; e++) begin
            @(negedge clk);
            if (btn_level[5]) r = e;
        end
        checks++;
        if (r != 6) begin
            errors++;
            $display("FAIL hold_level_rise edge=%0d want=6", r);
        end
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            checks++;
            if (btn_held[5] !== (j >= 10)) begin
                errors++;
                $display("FAIL held_j%0d got=%b want=%b", j, btn_held[5], j >= 10);
            end
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_hold got=%h inv=%h want=%h", got_a, got_b, exp_v);
            end
        end
        btn_in[5] = 1'b0;
        prev_held = btn_held[5];
        got = 1'b0;
        for (int e = 1; e <= 12 && !got; e++) begin
            @(negedge clk);
            if (btn_release[5]) begin
                got = 1'b1;
                checks++;
                if (btn_level[5] !== 1'b0 || btn_held[5] !== 1'b0 || prev_held !== 1'b1 || e != 6) begin
                    errors++;
                    $display("FAIL held_drop edge=%0d level=%b held=%b prev_held=%b", e, btn_level[5], btn_held[5], prev_held);
                end
            end
            prev_held = btn_held[5];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL held_release_timeout got=0 want=1");
        end
    endtask

    task automatic test_simultaneous();
        btn_in = '0;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 14; e++) begin
            btn_in[1] = 1'b1;
            btn_in[7] = 1'b1;
            btn_in[2] = !(e == 2 || e == 4);
            @(negedge clk);
            if (e == 6 || e == 10) begin
                checks++;
                if (btn_press !== ((e == 6) ? 8'h82 : 8'h04)) begin
                    errors++;
                    $display("FAIL simul_press_e%0d got=%h want=%h", e, btn_press, (e == 6) ? 8'h82 : 8'h04);
                end
            end
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_simul got=%h inv=%h want=%h", got_a, got_b, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        btn_in = '0;
        repeat (10) @(negedge clk);
        btn_in[4] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (btn_level !== 8'h10 || n_level !== 8'h10) begin
            errors++;
            $display("FAIL midpress_level got=%h inv=%h want=10", btn_level, n_level);
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (got_a !== '0 || got_b !== '0) begin
                errors++;
                $display("FAIL midpress_reset got=%h inv=%h want=0", got_a, got_b);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (got_a !== got_b || btn_release !== 8'h00 || btn_level !== ((e >= 6) ? 8'h10 : 8'h00)
                || btn_press !== ((e == 6) ? 8'h10 : 8'h00)) begin
                errors++;
                $display("FAIL repress_e%0d got=%h inv=%h", e, got_a, got_b);
            end
        end
    endtask

    task automatic test_random();
        btn_in = '0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 4) == 0) btn_in[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) btn_in = WIDTH'($urandom);
            @(negedge clk);
            checks++;
            if (got_a !== exp_v || got_b !== exp_v) begin
                errors++;
                $display("FAIL model_random c=%0d got=%h inv=%h want=%h", c, got_a, got_b, exp_v);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
